calc_key_sequencer: RTL and testbench

//   Upstream control stage of the calculator datapath. Accepts keypad events over a valid/ready handshake.

---
 rtl/calc_pkg.sv | 51 +++++
 rtl/calc_digit_accum.sv | 27 ++
 rtl/calc_key_sequencer.sv | 149 ++++++++++++++
 tb/tb_calc_key_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator key sequencer.
//   Key codes: 0-9 are digits, 10..13 are operators, 14 is equals, 15 is clear.
//   Op codes: the encoding the ALU expects on alu_op_code.
//   State encoding for the sequencer FSM.
//   Helpers that classify a key code and map an operator key to its op code.
package calc_pkg;

    localparam int unsigned KEY_W = 4;
    localparam int unsigned OP_W  = 2;

    localparam logic [KEY_W-1:0] KEY_ADD = 4'd10;
    localparam logic [KEY_W-1:0] KEY_SUB = 4'd11;
    localparam logic [KEY_W-1:0] KEY_MUL = 4'd12;
    localparam logic [KEY_W-1:0] KEY_DIV = 4'd13;
    localparam logic [KEY_W-1:0] KEY_EQ  = 4'd14;
    localparam logic [KEY_W-1:0] KEY_CLR = 4'd15;

    localparam logic [OP_W-1:0] OP_ADD = 2'b00;
    localparam logic [OP_W-1:0] OP_SUB = 2'b01;
    localparam logic [OP_W-1:0] OP_MUL = 2'b10;
    localparam logic [OP_W-1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_EXEC = 2'd2,
        S_RES  = 2'd3
    } state_t;

    function automatic logic is_digit(input logic [KEY_W-1:0] key);
        return key <= 4'd9;
    endfunction

    function automatic logic is_op(input logic [KEY_W-1:0] key);
        return (key >= KEY_ADD) && (key <= KEY_DIV);
    endfunction

    // Operator keys are not a plain bit slice of the op code, so map explicitly.
    function automatic logic [OP_W-1:0] key_to_op(input logic [KEY_W-1:0] key);
        logic [OP_W-1:0] op;
        op = OP_ADD;
        case (key)
            KEY_SUB: op = OP_SUB;
            KEY_MUL: op = OP_MUL;
            KEY_DIV: op = OP_DIV;
            default: op = OP_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/calc_digit_accum.sv
// Decimal digit accumulator: acc_next_c = acc*10 + digit, evaluated 4 bits wider
// than the operand so an entry that no longer fits in WIDTH bits is flagged.
//   acc         in   WIDTH  current operand value
//   digit       in   4      decimal digit 0-9
//   acc_next_c  out  WIDTH  low WIDTH bits of acc*10+digit (only meaningful when !ovf_c)
//   ovf_c       out  1      acc*10+digit exceeds 2^WIDTH-1
module calc_digit_accum #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [3:0]       digit,
    output logic [WIDTH-1:0] acc_next_c,
    output logic             ovf_c
);

    localparam int unsigned EXT_W = WIDTH + 4;

    logic [EXT_W-1:0] wide_c;

    // (2^WIDTH-1)*10+9 < 2^(WIDTH+4), so the wide sum never wraps.
    always_comb begin
        wide_c     = (EXT_W'(acc) * EXT_W'(10)) + EXT_W'(digit);
        acc_next_c = wide_c[WIDTH-1:0];
        ovf_c      = |wide_c[EXT_W-1:WIDTH];
    end

endmodule

// File: rtl/calc_key_sequencer.sv
// Keypad front end of the calculator datapath. Accepts key events over a
// valid/ready handshake, builds operands A and B from decimal digits, latches
// the operator, drives the combinational ALU and captures its result on '='.
//   clk, rst_n       clock, synchronous active-low reset
//   key_valid/ready  key handshake; transfer = key_valid & key_ready
//   key_code         0-9 digit, 10 add, 11 sub, 12 mul, 13 div, 14 equals, 15 clear
//   alu_op_a/b       registered operands to the ALU
//   alu_op_code      registered op code to the ALU
//   alu_result       combinational ALU result
//   display          value being entered, or last result
//   result_valid     one-cycle pulse when display takes a new result
//   entry_ovf        sticky: a digit was dropped because the operand would overflow
//   div_zero         sticky: '=' executed a divide by zero
// Build option: define CALC_CHAIN_EN to let an operator key in the result state
// chain the result into operand A of a new calculation.
module calc_key_sequencer
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic [3:0]       key_code,
    output logic [WIDTH-1:0] alu_op_a,
    output logic [WIDTH-1:0] alu_op_b,
    output logic [1:0]       alu_op_code,
    input  logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] display,
    output logic             result_valid,
    output logic             entry_ovf,
    output logic             div_zero
);

    state_t           state;
    logic             b_entered;
    logic             xfer_c;
    logic [WIDTH-1:0] acc_sel_c;
    logic [WIDTH-1:0] acc_next_c;
    logic             acc_ovf_c;

    assign xfer_c    = key_valid & key_ready;
    // One accumulator serves both operands; B is only built in S_B.
    assign acc_sel_c = (state == S_B) ? alu_op_b : alu_op_a;

    calc_digit_accum #(
        .WIDTH (WIDTH)
    ) u_digit_accum (
        .acc        (acc_sel_c),
        .digit      (key_code),
        .acc_next_c (acc_next_c),
        .ovf_c      (acc_ovf_c)
    );

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_A;
            b_entered    <= 1'b0;
            key_ready    <= 1'b1;
            alu_op_a     <= '0;
            alu_op_b     <= '0;
            alu_op_code  <= OP_ADD;
            display      <= '0;
            result_valid <= 1'b0;
            entry_ovf    <= 1'b0;
            div_zero     <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            if (state == S_EXEC) begin
                // Operands are stable registers here, so alu_result is settled.
                display      <= alu_result;
                result_valid <= 1'b1;
                if ((alu_op_code == OP_DIV) && (alu_op_b == '0)) begin
                    div_zero <= 1'b1;
                end
                key_ready <= 1'b1;
                state     <= S_RES;
            end else if (xfer_c) begin
                if (key_code == KEY_CLR) begin
                    alu_op_a    <= '0;
                    alu_op_b    <= '0;
                    alu_op_code <= OP_ADD;
                    display     <= '0;
                    entry_ovf   <= 1'b0;
                    div_zero    <= 1'b0;
                    b_entered   <= 1'b0;
                    state       <= S_A;
                end else begin
                    case (state)
                        S_A: begin
                            if (is_digit(key_code)) begin
                                if (acc_ovf_c) begin
                                    entry_ovf <= 1'b1;
                                end else begin
                                    alu_op_a <= acc_next_c;
                                    display  <= acc_next_c;
                                end
                            end else if (is_op(key_code)) begin
                                alu_op_code <= key_to_op(key_code);
                                alu_op_b    <= '0;
                                b_entered   <= 1'b0;
                                state       <= S_B;
                            end
                        end
                        S_B: begin
                            if (is_digit(key_code)) begin
                                // A leading zero still counts as B entry and locks the operator.
                                b_entered <= 1'b1;
                                if (acc_ovf_c) begin
                                    entry_ovf <= 1'b1;
                                end else begin
                                    alu_op_b <= acc_next_c;
                                    display  <= acc_next_c;
                                end
                            end else if (is_op(key_code)) begin
                                if (!b_entered) begin
                                    alu_op_code <= key_to_op(key_code);
                                end
                            end else if (key_code == KEY_EQ) begin
                                key_ready <= 1'b0;
                                state     <= S_EXEC;
                            end
                        end
                        S_RES: begin
                            if (is_digit(key_code)) begin
                                alu_op_a <= WIDTH'(key_code);
                                alu_op_b <= '0;
                                display  <= WIDTH'(key_code);
                                state    <= S_A;
                            end else if (is_op(key_code)) begin
`ifdef CALC_CHAIN_EN
                                alu_op_a    <= display;
                                alu_op_code <= key_to_op(key_code);
                                alu_op_b    <= '0;
                                b_entered   <= 1'b0;
                                state       <= S_B;
`endif
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_calc_key_sequencer.sv
// Directed bench for calc_key_sequencer with a behavioural stand-in for the ALU.
module tb_calc_key_sequencer;
    import calc_pkg::*;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             key_valid = 1'b0;
    logic             key_ready;
    logic [3:0]       key_code = 4'd0;
    logic [WIDTH-1:0] alu_op_a;
    logic [WIDTH-1:0] alu_op_b;
    logic [1:0]       alu_op_code;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] display;
    logic             result_valid;
    logic             entry_ovf;
    logic             div_zero;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // ALU stand-in: wrap-around arithmetic, divide by zero yields 0.
    always_comb begin
        case (alu_op_code)
            OP_ADD:  alu_result = WIDTH'(alu_op_a + alu_op_b);
            OP_SUB:  alu_result = WIDTH'(alu_op_a - alu_op_b);
            OP_MUL:  alu_result = WIDTH'(alu_op_a * alu_op_b);
            default: alu_result = (alu_op_b == '0) ? '0 : WIDTH'(alu_op_a / alu_op_b);
        endcase
    end

    calc_key_sequencer #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_valid    (key_valid),
        .key_ready    (key_ready),
        .key_code     (key_code),
        .alu_op_a     (alu_op_a),
        .alu_op_b     (alu_op_b),
        .alu_op_code  (alu_op_code),
        .alu_result   (alu_result),
        .display      (display),
        .result_valid (result_valid),
        .entry_ovf    (entry_ovf),
        .div_zero     (div_zero)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one key; waits (bounded) for key_ready, returns 1 time unit after the transfer edge.
    task automatic send_key(input logic [3:0] k);
        int waited;
        waited = 0;
        @(negedge clk);
        key_code  = k;
        key_valid = 1'b1;
        while (!key_ready && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        if (!key_ready) check("key_ready_timeout", 32'(key_ready), 32'd1);
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_op_a"},    32'(alu_op_a),     32'd0);
        check({tag, "_op_b"},    32'(alu_op_b),     32'd0);
        check({tag, "_op_code"}, 32'(alu_op_code),  32'd0);
        check({tag, "_display"}, 32'(display),      32'd0);
        check({tag, "_rv"},      32'(result_valid), 32'd0);
        check({tag, "_ovf"},     32'(entry_ovf),    32'd0);
        check({tag, "_dz"},      32'(div_zero),     32'd0);
        check({tag, "_ready"},   32'(key_ready),    32'd1);
    endtask

    initial begin
        // Power-on reset
        tick(2);
        check_idle("reset");
        rst_n = 1'b1;

        // 12 + 34 = 46
        send_key(4'd1);
        send_key(4'd2);
        check("t1_op_a_entry", 32'(alu_op_a), 32'd12);
        check("t1_disp_a", 32'(display), 32'd12);
        send_key(KEY_ADD);
        check("t1_op_code", 32'(alu_op_code), 32'd0);
        check("t1_op_b_zero", 32'(alu_op_b), 32'd0);
        send_key(4'd3);
        send_key(4'd4);
        check("t1_op_b", 32'(alu_op_b), 32'd34);
        check("t1_disp_b", 32'(display), 32'd34);
        send_key(KEY_EQ);
        check("t1_exec_ready", 32'(key_ready), 32'd0);
        check("t1_rv_n1", 32'(result_valid), 32'd0);
        check("t1_op_a", 32'(alu_op_a), 32'd12);
        tick(1);
        check("t1_rv_n2", 32'(result_valid), 32'd1);
        check("t1_display", 32'(display), 32'd46);
        tick(1);
        check("t1_rv_n3", 32'(result_valid), 32'd0);
        check("t1_ready_res", 32'(key_ready), 32'd1);
        // '=' in the result state is ignored
        send_key(KEY_EQ);
        tick(1);
        check("t1_eq_ign_rv", 32'(result_valid), 32'd0);
        check("t1_eq_ign_disp", 32'(display), 32'd46);

        // Entry overflow boundary
        send_key(KEY_CLR);
        send_key(4'd2);
        send_key(4'd5);
        send_key(4'd5);
        check("t2_max_op_a", 32'(alu_op_a), 32'd255);
        check("t2_max_ovf", 32'(entry_ovf), 32'd0);
        send_key(KEY_CLR);
        send_key(4'd2);
        send_key(4'd5);
        send_key(4'd6);
        check("t2_drop_op_a", 32'(alu_op_a), 32'd25);
        check("t2_drop_ovf", 32'(entry_ovf), 32'd1);
        check("t2_drop_disp", 32'(display), 32'd25);
        send_key(4'd7);
        check("t2_drop2_op_a", 32'(alu_op_a), 32'd25);
        send_key(KEY_CLR);
        check_idle("t2_clear");

        // 9 / 0
        send_key(4'd9);
        send_key(KEY_DIV);
        send_key(4'd0);
        send_key(KEY_EQ);
        tick(1);
        check("t3_rv", 32'(result_valid), 32'd1);
        check("t3_display", 32'(display), 32'd0);
        check("t3_dz", 32'(div_zero), 32'd1);
        tick(1);
        check("t3_rv_once", 32'(result_valid), 32'd0);
        send_key(4'd4);
        check("t3_dz_sticky", 32'(div_zero), 32'd1);
        check("t3_new_a", 32'(alu_op_a), 32'd4);
        send_key(KEY_CLR);
        check("t3_dz_clr", 32'(div_zero), 32'd0);

        // 5 + - 3 * = : operator replaced before B, ignored after
        send_key(4'd5);
        send_key(KEY_ADD);
        send_key(KEY_SUB);
        check("t4_op_repl", 32'(alu_op_code), 32'd1);
        send_key(4'd3);
        send_key(KEY_MUL);
        check("t4_op_kept", 32'(alu_op_code), 32'd1);
        send_key(KEY_EQ);
        tick(2);
        check("t4_display", 32'(display), 32'd2);

        // Wrap semantics: 3 - 5 = 254, 200 * 2 = 144
        send_key(KEY_CLR);
        send_key(4'd3);
        send_key(KEY_SUB);
        send_key(4'd5);
        send_key(KEY_EQ);
        tick(2);
        check("t4_sub_wrap", 32'(display), 32'd254);
        send_key(KEY_CLR);
        send_key(4'd2);
        send_key(4'd0);
        send_key(4'd0);
        send_key(KEY_MUL);
        send_key(4'd2);
        send_key(KEY_EQ);
        tick(2);
        check("t4_mul_wrap", 32'(display), 32'd144);

        // 3 + 4 = * 2 =
        send_key(KEY_CLR);
        send_key(4'd3);
        send_key(KEY_ADD);
        send_key(4'd4);
        send_key(KEY_EQ);
        tick(2);
        check("t5_first", 32'(display), 32'd7);
        send_key(KEY_MUL);
        send_key(4'd2);
        send_key(KEY_EQ);
        tick(2);
`ifdef CALC_CHAIN_EN
        check("t5_chain_disp", 32'(display), 32'd14);
        check("t5_chain_op_a", 32'(alu_op_a), 32'd7);
`else
        check("t5_nochain_disp", 32'(display), 32'd2);
        check("t5_nochain_op_a", 32'(alu_op_a), 32'd2);
`endif

        // Key held across S_EXEC is stalled, then accepted
        send_key(KEY_CLR);
        send_key(4'd6);
        send_key(KEY_ADD);
        send_key(4'd1);
        @(negedge clk);
        key_code  = KEY_EQ;
        key_valid = 1'b1;
        @(posedge clk);
        #1;
        key_code = 4'd7;
        check("t6_hold_ready", 32'(key_ready), 32'd0);
        tick(1);
        check("t6_hold_rv", 32'(result_valid), 32'd1);
        check("t6_hold_disp", 32'(display), 32'd7);
        tick(1);
        key_valid = 1'b0;
        check("t6_held_op_a", 32'(alu_op_a), 32'd7);
        check("t6_held_op_b", 32'(alu_op_b), 32'd0);
        check("t6_held_rv", 32'(result_valid), 32'd0);

        // Reset while in S_EXEC discards the pending result
        send_key(KEY_CLR);
        send_key(4'd1);
        send_key(KEY_ADD);
        send_key(4'd1);
        send_key(KEY_EQ);
        rst_n = 1'b0;
        tick(1);
        check_idle("t6_rst_exec");
        rst_n = 1'b1;
        tick(1);
        check("t6_rst_rv1", 32'(result_valid), 32'd0);
        check("t6_rst_disp", 32'(display), 32'd0);
        tick(1);
        check("t6_rst_rv2", 32'(result_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
